// File: rtl/rvfi_mon_pkg.sv
// rtl/rvfi_mon_pkg.sv - shared types and error priority encoder for the RVFI retire monitor
package rvfi_mon_pkg;

    typedef enum logic [1:0] {
        MON_IDLE   = 2'd0,
        MON_RUN    = 2'd1,
        MON_HALTED = 2'd2
    } mon_state_t;

    typedef enum logic [3:0] {
        ERR_NONE      = 4'd0,
        ERR_ORDER     = 4'd1,
        ERR_X0_WRITE  = 4'd2,
        ERR_X0_READ   = 4'd3,
        ERR_RS1       = 4'd4,
        ERR_RS2       = 4'd5,
        ERR_POST_HALT = 4'd6,
        ERR_INTR      = 4'd7
    } mon_err_e;

    // hits[i] set means check i fired; the lowest numbered check is reported
    function automatic mon_err_e prio_encode(input logic [7:1] hits);
        mon_err_e code;
        code = ERR_NONE;
        for (int i = 7; i >= 1; i--) begin
            if (hits[i]) begin
                code = mon_err_e'(4'(i));
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/rvfi_shadow_regfile.sv
// rtl/rvfi_shadow_regfile.sv - shadow integer register file with per-register written flags
module rvfi_shadow_regfile #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    output logic [WIDTH-1:0]      rs1_data,
    output logic                  rs1_valid,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [WIDTH-1:0]      rs2_data,
    output logic                  rs2_valid,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    // Next-state of the array: x0 is never stored, clear only drops the written flags
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        if (wr_en && (wr_addr != '0)) begin
            mem_d[wr_addr]   = wr_data;
            valid_d[wr_addr] = 1'b1;
        end
        if (clear) begin
            valid_d = '0;
        end
    end

    // Combinational read ports; x0 always reads as a known zero
    always_comb begin
        rs1_data  = (rs1_addr == '0) ? '0   : mem_q[rs1_addr];
        rs1_valid = (rs1_addr == '0) ? 1'b1 : valid_q[rs1_addr];
        rs2_data  = (rs2_addr == '0) ? '0   : mem_q[rs2_addr];
        rs2_valid = (rs2_addr == '0) ? 1'b1 : valid_q[rs2_addr];
    end

    // Data storage needs no reset: the valid flags gate every comparison
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    // Written flags
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/rvfi_retire_monitor.sv
// rtl/rvfi_retire_monitor.sv - checks RVFI retires against shadow state and captures the first violation
module rvfi_retire_monitor
    import rvfi_mon_pkg::*;
#(
    parameter int REG_DATA_WIDTH     = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int REGFILE_DEPTH      = 32,
    parameter int ERR_CNT_WIDTH      = 16
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          rvfi_valid,
    input  logic [63:0]                   rvfi_order,
    input  logic [31:0]                   rvfi_insn,
    input  logic                          rvfi_trap,
    input  logic                          rvfi_halt,
    input  logic                          rvfi_intr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rvfi_rs1_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rvfi_rs2_addr,
    input  logic [REG_DATA_WIDTH-1:0]     rvfi_rs1_rdata,
    input  logic [REG_DATA_WIDTH-1:0]     rvfi_rs2_rdata,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rvfi_rd_addr,
    input  logic [REG_DATA_WIDTH-1:0]     rvfi_rd_wdata,
    input  logic                          mon_clear,
    output logic                          mon_error,
    output logic [3:0]                    mon_err_code,
    output logic [63:0]                   mon_err_order,
    output logic [31:0]                   mon_err_insn,
    output logic [ERR_CNT_WIDTH-1:0]      mon_err_cnt,
    output logic [63:0]                   mon_retired_cnt,
    output logic                          mon_halted
);

    mon_state_t                state_q, state_d;
    logic [63:0]               exp_order_q, exp_order_d;
    logic                      error_q, error_d;
    mon_err_e                  err_code_q, err_code_d;
    logic [63:0]               err_order_q, err_order_d;
    logic [31:0]               err_insn_q, err_insn_d;
    logic [ERR_CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic [63:0]               retired_q, retired_d;

    logic [REG_DATA_WIDTH-1:0] sh_rs1_data, sh_rs2_data;
    logic                      sh_rs1_valid, sh_rs2_valid;
    logic                      sh_wr_en;
    logic [7:1]                hits;
    mon_err_e                  cur_code;

    assign sh_wr_en = rvfi_valid && !rvfi_trap && !mon_clear;

    rvfi_shadow_regfile #(
        .WIDTH      (REG_DATA_WIDTH),
        .ADDR_WIDTH (REGFILE_ADDR_WIDTH),
        .DEPTH      (REGFILE_DEPTH)
    ) u_shadow (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .clear     (mon_clear),
        .rs1_addr  (rvfi_rs1_addr),
        .rs1_data  (sh_rs1_data),
        .rs1_valid (sh_rs1_valid),
        .rs2_addr  (rvfi_rs2_addr),
        .rs2_data  (sh_rs2_data),
        .rs2_valid (sh_rs2_valid),
        .wr_en     (sh_wr_en),
        .wr_addr   (rvfi_rd_addr),
        .wr_data   (rvfi_rd_wdata)
    );

    // Evaluate every rule on this cycle's retire; trapped retires skip register checks
    always_comb begin
        hits    = '0;
        hits[1] = (rvfi_order != exp_order_q);
        hits[2] = !rvfi_trap && (rvfi_rd_addr == '0) && (rvfi_rd_wdata != '0);
        hits[3] = !rvfi_trap && (((rvfi_rs1_addr == '0) && (rvfi_rs1_rdata != '0)) ||
                                 ((rvfi_rs2_addr == '0) && (rvfi_rs2_rdata != '0)));
        hits[4] = !rvfi_trap && sh_rs1_valid && (rvfi_rs1_rdata != sh_rs1_data);
        hits[5] = !rvfi_trap && sh_rs2_valid && (rvfi_rs2_rdata != sh_rs2_data);
        hits[6] = (state_q == MON_HALTED);
        hits[7] = rvfi_intr;
        cur_code = rvfi_valid ? prio_encode(hits) : ERR_NONE;
    end

    // FSM, first-violation capture and counters; clear overrides a same-cycle retire
    always_comb begin
        state_d     = state_q;
        exp_order_d = exp_order_q;
        error_d     = error_q;
        err_code_d  = err_code_q;
        err_order_d = err_order_q;
        err_insn_d  = err_insn_q;
        err_cnt_d   = err_cnt_q;
        retired_d   = retired_q;
        if (mon_clear) begin
            state_d     = MON_IDLE;
            exp_order_d = '0;
            error_d     = 1'b0;
            err_code_d  = ERR_NONE;
            err_order_d = '0;
            err_insn_d  = '0;
            err_cnt_d   = '0;
            retired_d   = '0;
        end else if (rvfi_valid) begin
            exp_order_d = rvfi_order + 64'd1;
            retired_d   = retired_q + 64'd1;
            case (state_q)
                MON_IDLE: state_d = rvfi_halt ? MON_HALTED : MON_RUN;
                MON_RUN:  state_d = rvfi_halt ? MON_HALTED : MON_RUN;
                default:  state_d = state_q;
            endcase
            if (cur_code != ERR_NONE) begin
                if (!error_q) begin
                    error_d     = 1'b1;
                    err_code_d  = cur_code;
                    err_order_d = rvfi_order;
                    err_insn_d  = rvfi_insn;
                end
                if (err_cnt_q != {ERR_CNT_WIDTH{1'b1}}) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end
        end
    end

    // Monitor state registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= MON_IDLE;
            exp_order_q <= '0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_order_q <= '0;
            err_insn_q  <= '0;
            err_cnt_q   <= '0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            exp_order_q <= exp_order_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            err_order_q <= err_order_d;
            err_insn_q  <= err_insn_d;
            err_cnt_q   <= err_cnt_d;
            retired_q   <= retired_d;
        end
    end

    assign mon_error       = error_q;
    assign mon_err_code    = err_code_q;
    assign mon_err_order   = err_order_q;
    assign mon_err_insn    = err_insn_q;
    assign mon_err_cnt     = err_cnt_q;
    assign mon_retired_cnt = retired_q;
    assign mon_halted      = (state_q == MON_HALTED);

endmodule
